mac_col_acc: RTL and testbench
==============================

MAC_COL_ACC -- requirements
Module: mac_col_acc

Interface
REQ-001 Parameter BW, default 4: signed element width in bits.
REQ-002 Parameter PR, default 8: element pairs per operand; operand holds 2*PR elements.
REQ-003 Parameter BW_PSUM, default 2*BW+6: signed output width; SHALL be at least 2*BW+clog2(2*PR).
REQ-004 Parameter NUM_COL, default 8: columns in the array.
REQ-005 Parameter COL_ID, default 0: column index, range 0..NUM_COL-1.
REQ-006 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port i_inst, input, 3: instruction bits: [0] load, [1] execute, [2] accumulate.
REQ-009 Port q_in, input, 2*PR*BW: query/key operand, packed signed elements.
REQ-010 Port q_out, output, 2*PR*BW: registered query forwarded to the next column.
REQ-011 Port o_inst, output, 3: i_inst delayed one cycle, forwarded to the next column.
REQ-012 Port out, output, BW_PSUM: signed dot-product or accumulated result.
REQ-013 Port fifo_wr, output, 1: out valid for one cycle; drives the output FIFO write.
REQ-014 Port key_ready, output, 1: high once this column's key is captured.

Function
REQ-015 o_inst SHALL equal i_inst registered once; q_out SHALL equal the internal query register.
REQ-016 On any cycle with o_inst[0] or o_inst[1] high, the query register SHALL load q_in.
REQ-017 Key counter: in cycles with o_inst[0] high and key_ready low, cnt SHALL increment; at cnt == NUM_COL+1-COL_ID, key SHALL load q_in, cnt SHALL clear, and key_ready SHALL rise.
REQ-018 After key_ready is high, load cycles SHALL update only the query; key and cnt hold.
REQ-019 Load takes priority: with o_inst[0] and o_inst[1] both high, no result SHALL be produced.
REQ-020 Datapath: 2*PR signed BW x BW products summed at full width, then sign-extended to BW_PSUM.
REQ-021 Pipeline: execute accepted at o_inst cycle T; products registered at T+1; result registered and fifo_wr high at T+2. This is 3 cycles after i_inst.
REQ-022 With accumulate bit low, out SHALL equal the current dot product.
REQ-023 With accumulate bit high, out SHALL equal the previous out plus the dot product. Without REQ-030 enabled, overflow SHALL wrap in two's complement.
REQ-024 The accumulate bit SHALL be carried through the pipeline with its execute.
REQ-025 out SHALL hold its value between fifo_wr pulses.
REQ-026 Back-to-back executes SHALL yield one fifo_wr per cycle with no bubbles.
REQ-027 An execute before key_ready SHALL still produce a result, using key value 0.

Reset
REQ-028 On reset, the following SHALL clear to 0 on the next edge: cnt, key, query, o_inst, pipeline registers, instruction delay stages, out, fifo_wr and key_ready.
REQ-029 Reset mid-pipeline SHALL discard in-flight executes; no fifo_wr is asserted for them after reset.

Configuration
REQ-030 Macro MAC_COL_ACC_SAT_EN defined: the accumulate add SHALL saturate to the signed BW_PSUM range, from -2^(BW_PSUM-1) to 2^(BW_PSUM-1)-1.
REQ-031 Macro MAC_COL_ACC_SAT_EN undefined: no saturation logic SHALL exist; wrap per REQ-023.

Structure
REQ-032 Package mac_pkg SHALL hold the i_inst bit index constants (LOAD=0, EXEC=1, ACC=2) and the default BW, PR, NUM_COL values.
REQ-033 Sub-module mac_tree SHALL implement the product stage and registered adder tree (REQ-020, REQ-021) with parameters BW and PR.

Verification
REQ-034 COL_ID=0, NUM_COL=8: 9 load cycles with q_in = cycle index 1..9 -> key = operand 9; key_ready rises on the 9th o_inst load cycle. COL_ID=7 -> key captured on the 2nd load.
REQ-035 Key all +1, query all +2, one execute -> fifo_wr high exactly 3 cycles after i_inst; out = 4*PR = 32.
REQ-036 BW=4, key and query elements all -8 -> out = 16*64 = 1024, with no truncation.
REQ-037 Three executes with accumulate, dot products 10, -3, 5, each a separate result -> out 10, 7, 12 on consecutive cycles. First execute has accumulate low.
REQ-038 With MAC_COL_ACC_SAT_EN defined, accumulate repeatedly with product 1024 and BW_PSUM=14 -> out clamps at 8191. Undefined -> out wraps negative.
REQ-039 Reset asserted one cycle after an execute -> fifo_wr never pulses; key_ready=0; a reload then captures the key after the full count.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: instruction bit positions and default sizing shared by the MAC column files.
package mac_pkg;
    localparam int LOAD        = 0;
    localparam int EXEC        = 1;
    localparam int ACC         = 2;
    localparam int DEF_BW      = 4;
    localparam int DEF_PR      = 8;
    localparam int DEF_NUM_COL = 8;
endpackage

// File: rtl/mac_col_acc_if.sv
// mac_col_acc_if: instruction/operand bus between neighbouring MAC columns.
interface mac_col_acc_if import mac_pkg::*; #(
    parameter int BW      = DEF_BW,
    parameter int PR      = DEF_PR,
    parameter int BW_PSUM = 2*BW+6
);
    logic [2:0]                i_inst;
    logic [2*PR*BW-1:0]        q_in;
    logic [2*PR*BW-1:0]        q_out;
    logic [2:0]                o_inst;
    logic signed [BW_PSUM-1:0] out;
    logic                      fifo_wr;
    logic                      key_ready;
    modport master (output i_inst, q_in, input q_out, o_inst, out, fifo_wr, key_ready);
    modport slave (input i_inst, q_in, output q_out, o_inst, out, fifo_wr, key_ready);
endinterface

// File: rtl/mac_tree.sv
// mac_tree: registered signed element products feeding a full-width adder tree.
module mac_tree import mac_pkg::*; #(
    parameter int BW = DEF_BW,
    parameter int PR = DEF_PR
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [2*PR*BW-1:0]                   i_a,
    input  logic [2*PR*BW-1:0]                   i_b,
    output logic signed [2*BW+$clog2(2*PR)-1:0]  o_sum
);
    localparam int SW = 2*BW + $clog2(2*PR);
    logic signed [2*BW-1:0] r_prod [2*PR];
    // Operands widened first so the product carries its full 2*BW bits.
    always_ff @(posedge clk)
        for (int i = 0; i < 2*PR; i++)
            r_prod[i] <= reset ? '0 : (2*BW)'($signed(i_a[i*BW +: BW])) * (2*BW)'($signed(i_b[i*BW +: BW]));
    always_comb begin
        o_sum = '0;
        for (int i = 0; i < 2*PR; i++)
            o_sum = o_sum + SW'(r_prod[i]);
    end
endmodule

// File: rtl/mac_col_acc.sv
// mac_col_acc: one systolic column; captures a key, forwards query/instruction, emits dot products.
// Optional MAC_COL_ACC_SAT_EN makes the accumulate add saturate instead of wrap.
module mac_col_acc import mac_pkg::*; #(
    parameter int BW      = DEF_BW,
    parameter int PR      = DEF_PR,
    parameter int BW_PSUM = 2*BW+6,
    parameter int NUM_COL = DEF_NUM_COL,
    parameter int COL_ID  = 0
) (
    input logic          clk,
    input logic          reset,
    mac_col_acc_if.slave bus
);
    localparam int SW = 2*BW + $clog2(2*PR);
    localparam int CW = $clog2(NUM_COL + 2);
    // Number of earlier loads seen when the capturing load arrives.
    localparam logic [CW-1:0] KEY_AT = CW'(NUM_COL - COL_ID);
    logic [2:0]                r_o_inst;
    logic [2*PR*BW-1:0]        r_query;
    logic [2*PR*BW-1:0]        r_key;
    logic [CW-1:0]             r_cnt;
    logic                      r_key_ready;
    logic                      r_v1;
    logic                      r_acc1;
    logic                      r_fifo_wr;
    logic signed [BW_PSUM-1:0] r_out;
    logic signed [SW-1:0]      w_sum;
    logic signed [BW_PSUM-1:0] w_ext;
    logic signed [BW_PSUM-1:0] w_nxt;
    logic                      w_ld;
    logic                      w_ex;
    logic                      w_cnt_en;
    logic                      w_hit;
    assign w_ld     = r_o_inst[LOAD];
    assign w_ex     = r_o_inst[EXEC] & ~w_ld;
    assign w_cnt_en = w_ld & ~r_key_ready;
    assign w_hit    = w_cnt_en & (r_cnt == KEY_AT);
    assign w_ext    = BW_PSUM'(w_sum);
    mac_tree #(.BW(BW), .PR(PR)) u_tree (
        .clk   (clk),
        .reset (reset),
        .i_a   (r_key),
        .i_b   (bus.q_in),
        .o_sum (w_sum)
    );
`ifdef MAC_COL_ACC_SAT_EN
    localparam logic signed [BW_PSUM-1:0] MAXV = {1'b0, {(BW_PSUM-1){1'b1}}};
    localparam logic signed [BW_PSUM-1:0] MINV = {1'b1, {(BW_PSUM-1){1'b0}}};
    logic signed [BW_PSUM:0] w_add;
    assign w_add = (BW_PSUM+1)'(r_out) + (BW_PSUM+1)'(w_ext);
    // Top two bits disagree exactly when the sum left the BW_PSUM range.
    assign w_nxt = ~r_acc1 ? w_ext :
                   (w_add[BW_PSUM] != w_add[BW_PSUM-1]) ? (w_add[BW_PSUM] ? MINV : MAXV) :
                   w_add[BW_PSUM-1:0];
`else
    assign w_nxt = r_acc1 ? r_out + w_ext : w_ext;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            r_o_inst    <= '0;
            r_query     <= '0;
            r_key       <= '0;
            r_cnt       <= '0;
            r_key_ready <= 1'b0;
            r_v1        <= 1'b0;
            r_acc1      <= 1'b0;
            r_fifo_wr   <= 1'b0;
            r_out       <= '0;
        end else begin
            r_o_inst  <= bus.i_inst;
            r_v1      <= w_ex;
            r_acc1    <= r_o_inst[ACC];
            r_fifo_wr <= r_v1;
            if (w_ld | r_o_inst[EXEC]) r_query <= bus.q_in;
            if (w_cnt_en) r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
            if (w_hit) r_key <= bus.q_in;
            if (w_hit) r_key_ready <= 1'b1;
            if (r_v1) r_out <= w_nxt;
        end
    end
    assign bus.q_out     = r_query;
    assign bus.o_inst    = r_o_inst;
    assign bus.out       = r_out;
    assign bus.fifo_wr   = r_fifo_wr;
    assign bus.key_ready = r_key_ready;
endmodule

// File: tb/tb_mac_col_acc.sv
// tb_mac_col_acc: directed stimulus with a result scoreboard for columns 0 and 7.
module tb_mac_col_acc;
    import mac_pkg::*;
    localparam int PS = 14;
    localparam logic [2:0] LD  = 3'b001;
    localparam logic [2:0] EX  = 3'b010;
    localparam logic [2:0] LX  = 3'b011;
    localparam logic [2:0] EXA = 3'b110;
    typedef struct {
        int                   cyc;
        logic signed [PS-1:0] val;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mac_col_acc_if #(.BW(4), .PR(8), .BW_PSUM(PS)) bus0 ();
    mac_col_acc_if #(.BW(4), .PR(8), .BW_PSUM(PS)) bus7 ();
    assign bus7.i_inst = bus0.i_inst;
    assign bus7.q_in   = bus0.q_in;
    mac_col_acc #(.COL_ID(0)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
    mac_col_acc #(.COL_ID(7)) dut7 (.clk(clk), .reset(rst), .bus(bus7));
    exp_t                 sb[$];
    int                   cyc = 0;
    int                   n_pass = 0;
    int                   n_tot = 0;
    logic [2:0]           m_oi;
    logic [63:0]          m_q;
    logic [63:0]          m_key;
    logic [63:0]          pend;
    int                   m_cnt[2];
    logic                 m_kr[2];
    int                   m_acc;
    logic signed [PS-1:0] m_vis;
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask
    function automatic int dot(logic [63:0] k, logic [63:0] q);
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'($signed(k[i*4 +: 4])) * int'($signed(q[i*4 +: 4]));
        return s;
    endfunction
    function automatic int accum(int a, int d);
        int t;
        logic signed [PS-1:0] w;
        t = a + d;
        w = PS'(t);
`ifdef MAC_COL_ACC_SAT_EN
        return t > 8191 ? 8191 : (t < -8192 ? -8192 : t);
`else
        return int'(w);
`endif
    endfunction
    // Advance one clock: update the expected state from this cycle's inputs, then compare.
    task automatic tick();
        bit   wr;
        exp_t e;
        if (rst) begin
            m_oi = '0; m_q = '0; m_key = '0; m_acc = 0; m_vis = '0;
            m_cnt = '{0, 0};
            m_kr = '{1'b0, 1'b0};
            sb.delete();
        end else begin
            if (m_oi[EXEC] && !m_oi[LOAD]) begin
                m_acc = m_oi[ACC] ? accum(m_acc, dot(m_key, bus0.q_in)) : dot(m_key, bus0.q_in);
                sb.push_back('{cyc + 2, PS'(m_acc)});
            end
            for (int c = 0; c < 2; c++)
                if (m_oi[LOAD] && !m_kr[c]) begin
                    m_cnt[c]++;
                    if (m_cnt[c] == (c == 0 ? 9 : 2)) begin
                        m_kr[c] = 1'b1;
                        m_cnt[c] = 0;
                        if (c == 0) m_key = bus0.q_in;
                    end
                end
            if (m_oi[LOAD] || m_oi[EXEC]) m_q = bus0.q_in;
            m_oi = bus0.i_inst;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("o_inst", 64'(bus0.o_inst), 64'(m_oi));
        chk("q_out", bus0.q_out, m_q);
        chk("key_ready0", 64'(bus0.key_ready), 64'(m_kr[0]));
        chk("key_ready7", 64'(bus7.key_ready), 64'(m_kr[1]));
        wr = 1'b0;
        if (sb.size() != 0) wr = (sb[0].cyc == cyc);
        chk("fifo_wr", 64'(bus0.fifo_wr), 64'(wr));
        if (wr) begin
            e = sb.pop_front();
            m_vis = e.val;
        end
        chk("out", 64'(bus0.out), 64'(m_vis));
    endtask
    // The operand belonging to an instruction arrives one cycle behind it.
    task automatic step(logic [2:0] inst, logic [63:0] q);
        tick();
        bus0.i_inst = inst;
        bus0.q_in = pend;
        pend = q;
    endtask
    task automatic idle(int n);
        repeat (n) step(3'b000, 64'd0);
    endtask
    task automatic do_rst(int n);
        rst = 1'b1;
        bus0.i_inst = '0;
        bus0.q_in = '0;
        pend = '0;
        repeat (n) tick();
        rst = 1'b0;
    endtask
    task automatic load_key(logic [63:0] k);
        for (int i = 1; i <= 9; i++) step(LD, i == 9 ? k : 64'(i));
    endtask
    initial begin
        bus0.i_inst = '0;
        bus0.q_in = '0;
        pend = '0;
        do_rst(3);
        step(EX, {16{4'h1}});
        idle(4);
        load_key(64'd9);
        idle(2);
        step(EX, {16{4'h1}});
        step(LD, {16{4'h3}});
        step(EX, {16{4'h1}});
        step(LX, {16{4'h2}});
        idle(4);
        do_rst(2);
        load_key({16{4'h1}});
        step(EX, {16{4'h2}});
        idle(4);
        step(EX, 64'h37);
        step(EXA, 64'hD);
        step(EXA, 64'h5);
        idle(4);
        do_rst(2);
        load_key({16{4'h8}});
        step(EX, {16{4'h8}});
        idle(4);
        step(EX, {16{4'h8}});
        repeat (9) step(EXA, {16{4'h8}});
        idle(4);
        step(EX, {16{4'h8}});
        step(3'b000, 64'd0);
        do_rst(1);
        idle(4);
        step(EX, {16{4'h8}});
        idle(2);
        do_rst(1);
        idle(4);
        load_key({16{4'h1}});
        step(EX, {16{4'h3}});
        idle(4);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
